lr35902_joy_scan: RTL

Parametrised joypad/key-matrix port for the LR35902 I/O space, generalising the P1-style register to NSEL active-low select outputs and NIN active-low sense inputs. Each sense input is synchronised and debounced. The block raises a one-clock interrupt pulse on a debounced high-to-low transition, and masks that interrupt for a settling window after every select write. It sits on the CPU I/O bus beside the other peripherals and drives the interrupt controller's joypad request line.

---
 rtl/lr35902_joy_scan.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/lr35902_joy_scan.sv
// lr35902_joy_scan: joypad / key-matrix port on the LR35902 I/O bus.
// NSEL active-low select outputs, NIN active-low sense inputs. Each sense
// input is synchronised and debounced. A debounced high-to-low transition
// raises a one-clock irq pulse, except inside the settling window that
// follows any select write.
module lr35902_joy_scan #(
  parameter int NSEL     = 2,
  parameter int NIN      = 4,
  parameter int DEBOUNCE = 4,
  parameter int MASK     = DEBOUNCE + 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      din,
  output logic [7:0]      dout,
  input  logic            read,
  input  logic            write,
  output logic            irq,
  input  logic [NIN-1:0]  pin,
  output logic [NSEL-1:0] psel
);

  // Counter widths are kept at least one bit so degenerate parameters still elaborate.
  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int MW = (MASK > 0) ? $clog2(MASK + 1) : 1;

  if ((NSEL + NIN) > 8 || NSEL < 1 || NIN < 1) begin : g_bad_width
    $error("lr35902_joy_scan: need NSEL>=1, NIN>=1 and NSEL+NIN<=8");
  end
  if (DEBOUNCE < 1) begin : g_bad_debounce
    $error("lr35902_joy_scan: DEBOUNCE must be >= 1");
  end
  if (MASK < 0) begin : g_bad_mask
    $error("lr35902_joy_scan: MASK must be >= 0");
  end

  logic [NIN-1:0]  r_s0;
  logic [NIN-1:0]  r_s1;
  logic [NIN-1:0]  r_deb;
  logic [CW-1:0]   r_cnt [NIN];
  logic [MW-1:0]   r_mcnt;
  logic [NSEL-1:0] r_psel;
  logic [7:0]      r_dout;
  logic            r_irq;

  logic [NIN-1:0]  w_deb_next;
  logic [CW-1:0]   w_cnt_next [NIN];
  logic [MW-1:0]   w_mcnt_next;
  logic            w_irq_next;
  logic [7:0]      w_rdata;
  logic [7:0]      w_unused_din;

  // Only the select field of din is stored; the rest is deliberately ignored.
  assign w_unused_din = din;

  assign dout = r_dout;
  assign irq  = r_irq;
  assign psel = r_psel;

  // Read image: unused high bits read 1, then select field, then debounced inputs.
  always_comb begin
    w_rdata                  = '1;
    w_rdata[NIN-1:0]         = r_deb;
    w_rdata[NIN+NSEL-1:NIN]  = r_psel;
  end

  // Per-input debounce: a change is accepted only after DEBOUNCE consecutive
  // disagreeing samples; any agreeing sample restarts the count.
  always_comb begin
    w_deb_next = r_deb;
    w_cnt_next = '{default: '0};
    for (int unsigned i = 0; i < NIN; i++) begin
      if (r_s1[i] != r_deb[i]) begin
        if (r_cnt[i] == CW'(DEBOUNCE - 1)) begin
          w_deb_next[i] = r_s1[i];
        end else begin
          w_cnt_next[i] = r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Settling window: reloaded on every write, otherwise counts down to zero.
  // The irq gate looks at the post-edge window value so that a fall landing
  // exactly MASK edges after the write is already allowed through.
  always_comb begin
    if (write) begin
      w_mcnt_next = MW'(MASK);
    end else if (r_mcnt != '0) begin
      w_mcnt_next = r_mcnt - 1'b1;
    end else begin
      w_mcnt_next = '0;
    end
    w_irq_next = (|(r_deb & ~w_deb_next)) && (w_mcnt_next == '0);
  end

  // Two-flop synchroniser for the asynchronous sense inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s0 <= '1;
      r_s1 <= '1;
    end else begin
      r_s0 <= pin;
      r_s1 <= r_s0;
    end
  end

  // Debounced state and per-input stability counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_deb <= '1;
      for (int unsigned i = 0; i < NIN; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_deb <= w_deb_next;
      for (int unsigned i = 0; i < NIN; i++) begin
        r_cnt[i] <= w_cnt_next[i];
      end
    end
  end

  // Mask window counter and interrupt pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcnt <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_mcnt <= w_mcnt_next;
      r_irq  <= w_irq_next;
    end
  end

  // CPU register access: select write and registered read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_psel <= '0;
      r_dout <= '1;
    end else begin
      if (write) begin
        r_psel <= din[NIN+NSEL-1:NIN];
      end
      if (read) begin
        r_dout <= w_rdata;
      end
    end
  end

endmodule
